// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the Sobel front end: pixel width, default frame geometry,
// counter widths and the window-generator state type.
package sobel_window_gen_pkg;

   localparam int unsigned PIXEL_WIDTH_OUT = 8;
   localparam int unsigned IMG_WIDTH_DEF   = 16;
   localparam int unsigned IMG_HEIGHT_DEF  = 16;
   localparam int unsigned COL_W           = $clog2(IMG_WIDTH_DEF);
   localparam int unsigned ROW_W           = $clog2(IMG_HEIGHT_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } win_state_t;

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// One-line pixel delay built as an enabled shift register.
// The output is the pixel written DEPTH enabled cycles earlier.
module sobel_line_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [DEPTH-1:0][WIDTH-1:0] sr_q;
   logic [DEPTH-1:0][WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (en_i) begin
         sr_d = {sr_q[DEPTH-2:0], din_i};
      end
   end

   // Contents are never observed before being refilled, so no reset is needed.
   always_ff @(posedge clk_i) begin
      sr_q <= sr_d;
   end

   assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream to 3x3 neighbourhood generator feeding the Sobel core.
// Two line buffers supply the previous rows; windows are emitted for interior pixels only.
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [PIXEL_WIDTH_OUT-1:0]            pix_i,
   input  logic                                  pix_valid_i,
   input  logic                                  sof_i,
   output logic [0:2][0:2][PIXEL_WIDTH_OUT-1:0]  matrix_o,
   output logic                                  win_valid_o,
   output logic                                  frame_done_o,
   output logic                                  frame_err_o
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);

   win_state_t                          state_q, state_d;
   logic [CW-1:0]                       col_q, col_d;
   logic [RW-1:0]                       row_q, row_d;
   logic [0:2][0:2][PIXEL_WIDTH_OUT-1:0] win_q, win_d;
   logic                                win_valid_q, win_valid_d;
   logic                                frame_done_q, frame_done_d;
   logic                                frame_err_q, frame_err_d;

   logic                                accept;
   logic [PIXEL_WIDTH_OUT-1:0]          lb0_out, lb1_out;
   logic                                last_col, last_row;

   assign accept   = pix_valid_i && (sof_i || (state_q != IDLE));
   assign last_col = (col_q == CW'(IMG_WIDTH - 1));
   assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

   sobel_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIXEL_WIDTH_OUT)
   ) u_lb0 (
      .clk_i  (clk_i),
      .en_i   (accept),
      .din_i  (pix_i),
      .dout_o (lb0_out)
   );

   sobel_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIXEL_WIDTH_OUT)
   ) u_lb1 (
      .clk_i  (clk_i),
      .en_i   (accept),
      .din_i  (lb0_out),
      .dout_o (lb1_out)
   );

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      if (accept) begin
         for (int unsigned r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_out;
         win_d[1][2] = lb0_out;
         win_d[2][2] = pix_i;

         if (sof_i) begin
            // This pixel is (0,0) of a new frame, so the counters land on (0,1).
            frame_err_d = (state_q != IDLE);
            state_d     = FILL;
            col_d       = CW'(1);
            row_d       = '0;
         end else begin
            win_valid_d = (state_q == RUN) && (col_q >= CW'(2));
            if (last_col) begin
               col_d = '0;
               row_d = row_q + 1'b1;
               if (last_row) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
                  row_d        = '0;
               end else if ((state_q == FILL) && (row_q == RW'(1))) begin
                  state_d = RUN;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign matrix_o     = win_q;
   assign win_valid_o  = win_valid_q;
   assign frame_done_o = frame_done_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: directed frames plus random traffic, checked against
// a frame-array reference model that derives windows from pixel coordinates.
module tb_sobel_window_gen;
   import sobel_window_gen_pkg::*;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = PIXEL_WIDTH_OUT;

   typedef logic [0:2][0:2][PW-1:0] mat_t;

   logic          clk_i;
   logic          rst_i;
   logic [PW-1:0] pix_i;
   logic          pix_valid_i;
   logic          sof_i;
   mat_t          matrix_o;
   logic          win_valid_o;
   logic          frame_done_o;
   logic          frame_err_o;

   sobel_window_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pix_i        (pix_i),
      .pix_valid_i  (pix_valid_i),
      .sof_i        (sof_i),
      .matrix_o     (matrix_o),
      .win_valid_o  (win_valid_o),
      .frame_done_o (frame_done_o),
      .frame_err_o  (frame_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: current frame position and every accepted pixel by coordinate.
   bit   m_active;
   int   m_r, m_c;
   int   img [H][W];
   mat_t m_win;
   bit   m_have_win;
   int   dut_strobes = 0;
   int   mdl_strobes = 0;

   task automatic cyc(input bit v, input bit s, input logic [PW-1:0] p);
      bit acc;
      bit e_valid, e_done, e_err;
      pix_valid_i = v;
      sof_i       = s;
      pix_i       = p;
      acc = 0; e_valid = 0; e_done = 0; e_err = 0;
      if (v) begin
         if (s) begin
            e_err = m_active;
            m_active = 1; m_r = 0; m_c = 0; acc = 1;
         end else if (m_active) begin
            acc = 1;
         end
      end
      if (acc) begin
         img[m_r][m_c] = int'(p);
         if (m_r >= 2 && m_c >= 2) begin
            e_valid = 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  m_win[i][j] = PW'(img[m_r-2+i][m_c-2+j]);
            m_have_win = 1;
            mdl_strobes++;
         end else begin
            m_have_win = 0;
         end
         m_c++;
         if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) begin
               m_r = 0; m_active = 0; e_done = 1;
            end
         end
      end
      @(posedge clk_i);
      #1;
      chk("win_valid", 80'(win_valid_o), 80'(e_valid));
      chk("frame_done", 80'(frame_done_o), 80'(e_done));
      chk("frame_err", 80'(frame_err_o), 80'(e_err));
      if (m_have_win) chk("matrix", 80'(matrix_o), 80'(m_win));
      if (win_valid_o) dut_strobes++;
   endtask

   // Called right after cyc(), i.e. 1 time unit past a rising edge.
   task automatic async_reset();
      pix_valid_i = 0;
      sof_i       = 0;
      #2;
      rst_i = 1;
      #1;
      chk("rst_win_valid", 80'(win_valid_o), 80'(0));
      chk("rst_matrix", 80'(matrix_o), 80'(0));
      chk("rst_pulses", 80'({frame_done_o, frame_err_o}), 80'(0));
      m_active = 0; m_r = 0; m_c = 0;
      m_win = '0; m_have_win = 1;
      @(negedge clk_i);
      rst_i = 0;
   endtask

   task automatic send_frame(input int base, input bit stall);
      mat_t first;
      for (int idx = 0; idx < W*H; idx++) begin
         if (stall) cyc(0, 0, PW'($urandom));
         cyc(1, idx == 0, PW'(base + idx));
         if (idx == 10) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  first[i][j] = PW'(base + 4*i + j);
            chk("first_win", 80'(matrix_o), 80'(first));
         end
      end
   endtask

   initial begin
      int s0;
      rst_i = 1; pix_valid_i = 0; sof_i = 0; pix_i = '0;
      m_active = 0; m_r = 0; m_c = 0; m_win = '0; m_have_win = 1;
      @(posedge clk_i); #1;
      chk("reset_matrix", 80'(matrix_o), 80'(0));
      chk("reset_flags", 80'({win_valid_o, frame_done_o, frame_err_o}), 80'(0));
      @(negedge clk_i);
      rst_i = 0;
      @(posedge clk_i); #1;

      // 1. basic frame
      s0 = dut_strobes;
      send_frame(0, 0);
      chk("s1_strobes", 80'(dut_strobes - s0), 80'(4));
      for (int k = 0; k < 3; k++) cyc(0, 0, '0);

      // 2. stalls every other cycle
      s0 = dut_strobes;
      send_frame(0, 1);
      chk("s2_strobes", 80'(dut_strobes - s0), 80'(4));

      // 3. pixels before sof are dropped
      for (int k = 0; k < 5; k++) cyc(1, 0, PW'(200 + k));
      s0 = dut_strobes;
      send_frame(0, 0);
      chk("s3_strobes", 80'(dut_strobes - s0), 80'(4));

      // 4. restart at pixel index 9
      cyc(1, 1, '0);
      for (int k = 1; k < 9; k++) cyc(1, 0, PW'(k));
      s0 = dut_strobes;
      send_frame(0, 0);
      chk("s4_strobes", 80'(dut_strobes - s0), 80'(4));

      // 5. async reset during RUN, then pixels without sof are ignored
      cyc(1, 1, '0);
      for (int k = 1; k < 12; k++) cyc(1, 0, PW'(k));
      async_reset();
      s0 = dut_strobes;
      for (int k = 0; k < 20; k++) cyc(1, 0, PW'(k));
      chk("s5_no_output", 80'(dut_strobes - s0), 80'(0));
      send_frame(0, 0);

      // 6. back-to-back frames
      s0 = dut_strobes;
      send_frame(0, 0);
      send_frame(100, 0);
      chk("s6_strobes", 80'(dut_strobes - s0), 80'(8));

      // random traffic with stalls, restarts and occasional resets
      for (int n = 0; n < 3000; n++) begin
         bit v, s;
         v = ($urandom_range(0, 9) < 7);
         s = v && (m_active ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0));
         cyc(v, s, PW'($urandom));
         if ($urandom_range(0, 499) == 0) async_reset();
      end
      chk("total_strobes", 80'(dut_strobes), 80'(mdl_strobes));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
